mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//  Multi-cycle iterative multiplier controller for the execute stage; replaces the
//  single-cycle combinational multiply path beside the ALU block. Accepts one
//  MUL/MLA/UMULL/UMLAL/SMULL/SMLAL op, iterates shift-add over the multiplier
//  operand, applies sign fix-up and accumulation, and returns a 64-bit result
//  plus N/Z flags. Busy holds the pipeline stall until done.
// PARAMETERS
//  BITS_PER_CYCLE  2   multiplier bits retired per CALC cycle; legal 1,2,4,8 (divides 32)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  start      in   1   request; accepted only when busy==0
//  cmd        in   3   op code, mul_cmd_t (sampled at accept)
//  a          in   32  multiplicand (Rm)
//  b          in   32  multiplier (Rs)
//  acc_lo     in   32  accumulate low (Rn for MLA, RdLo for xMLAL)
//  acc_hi     in   32  accumulate high (RdHi for xMLAL)
//  flush      in   1   synchronous abort; higher priority than start
//  busy       out  1   op in flight (accept cycle through FIX inclusive)
//  done       out  1   one-cycle pulse, results valid this cycle and held after
//  result_lo  out  32  product/sum bits [31:0]
//  result_hi  out  32  product/sum bits [63:32]; 0 for MUL/MLA
//  flag_n     out  1   long: result_hi[31]; short: result_lo[31]
//  flag_z     out  1   long: all 64 bits zero; short: result_lo==0
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy, done, result_lo, result_hi, flag_n, flag_z = 0.
//  - cmd encoding: MUL=000 MLA=001 UMULL=100 UMLAL=101 SMULL=110 SMLAL=111;
//    cmd[2]=long, cmd[1]=signed, cmd[0]=accumulate. 010/011 are treated as MUL/MLA.
//  - FSM IDLE -> CALC -> FIX -> IDLE.
//    IDLE: start&&!flush -> latch ops, count=0, prod=0, busy=1 from next cycle; ->CALC.
//      Signed ops latch |a|, |b| and neg = a[31]^b[31]; unsigned ops neg=0.
//    CALC: per cycle add (|a| * b_chunk) << (count*BITS_PER_CYCLE) into 64-bit prod;
//      b_chunk = low BITS_PER_CYCLE bits of shifting multiplier; 32/BITS_PER_CYCLE cycles.
//    FIX: r = neg ? -prod : prod (64-bit two's complement);
//      accumulate adds {acc_hi,acc_lo} (long) or {32'b0,acc_lo} (short), mod 2^64;
//      short ops: result_hi=0, result_lo=r[31:0]. Register results+flags, done=1, ->IDLE.
//  - Latency start-accept to done = 32/BITS_PER_CYCLE + 1 cycles (17 at default).
//    Back-to-back: start in the done cycle is accepted (busy=0 in that cycle).
//  - start while busy is ignored; requester holds start until it sees busy=0.
//  - Accumulate operands are latched at accept, not at FIX.
//  - -2^31 * -2^31 signed: |x| = 2^31 as unsigned 32-bit, result 0x4000_0000_0000_0000.
//  - flush in any state: next state IDLE, busy=0, no done; results/flags keep last values.
//  - flush and start same cycle: flush wins, start dropped.
//  - Reset mid-op: immediate IDLE, outputs cleared, no done.
//  - done is never asserted while busy=0 except in the FIX->IDLE cycle; done&&busy never both 1.
// STRUCTURE
//  - Package mul_pkg: mul_cmd_t enum (above codes), mul_state_t {IDLE,CALC,FIX},
//    localparam MUL_ITERS = 32/BITS_PER_CYCLE.
//  - Sub-module mul_step: combinational 32 x BITS_PER_CYCLE partial-product adder
//    (prod_in, mcand, chunk, shift -> prod_out); FSM, counter, fix-up in top.
// TESTING
//  - MUL a=7 b=6 -> done after 17 cycles, result_lo=42, result_hi=0, n=0 z=0.
//  - UMULL a=b=0xFFFF_FFFF -> hi=0xFFFF_FFFE lo=0x0000_0001; n=1 z=0.
//  - SMLAL a=-3 b=5 acc={0,0xF} -> {hi,lo}=0x0000_0000_0000_0000; z=1 n=0.
//  - SMULL a=b=0x8000_0000 -> hi=0x4000_0000 lo=0; MLA a=2 b=3 acc_lo=0xFFFF_FFFA -> lo=0, z=1.
//  - start pulsed at cycle 5 of an op -> ignored; start held through done -> next op
//    accepted in done cycle, second done exactly 17 cycles later.
//  - flush at CALC cycle 8 -> busy=0 next cycle, no done, outputs unchanged;
//    reset at cycle 3 -> all outputs 0 immediately.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiplier sequencer.
package mul_pkg;

   // cmd[2] = long (64-bit result), cmd[1] = signed, cmd[0] = accumulate
   typedef enum logic [2:0] {
      CMD_MUL   = 3'b000,
      CMD_MLA   = 3'b001,
      CMD_UMULL = 3'b100,
      CMD_UMLAL = 3'b101,
      CMD_SMULL = 3'b110,
      CMD_SMLAL = 3'b111
   } mul_cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } mul_state_t;

   localparam int BITS_PER_CYCLE_DEF = 2;
   localparam int MUL_ITERS          = 32 / BITS_PER_CYCLE_DEF;

   // Magnitude of a 32-bit two's complement value; -2^31 maps to 2^31 unsigned.
   function automatic logic [31:0] abs32(input logic [31:0] x);
      return x[31] ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step: adds (mcand * chunk) << shift into the running 64-bit product.
module mul_step #(
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic [63:0]               prod_in,
   input  logic [31:0]               mcand,
   input  logic [BITS_PER_CYCLE-1:0] chunk,
   input  logic [5:0]                shift,
   output logic [63:0]               prod_out
);

   logic [63:0] partial;

   // Partial product never exceeds 64 bits because shift <= 32 - BITS_PER_CYCLE.
   always_comb begin
      partial  = 64'(mcand) * 64'(chunk);
      prod_out = prod_in + (partial << shift);
   end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier controller with sign fix-up and accumulate.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for start; results/flags hold the last completed op
//  CALC  | retiring BITS_PER_CYCLE multiplier bits per cycle into prod
//  FIX   | negate if needed, add accumulator, register results, pulse done
module mul_sequencer
   import mul_pkg::*;
#(
   parameter int BITS_PER_CYCLE = BITS_PER_CYCLE_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  cmd,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] acc_lo,
   input  logic [31:0] acc_hi,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result_lo,
   output logic [31:0] result_hi,
   output logic        flag_n,
   output logic        flag_z
);

   localparam int ITERS = 32 / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(ITERS);

   mul_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      mcand;
   logic [31:0]      mplier;
   logic [63:0]      prod;
   logic [63:0]      prod_next;
   logic [63:0]      acc;
   logic             neg;
   logic             is_long;
   logic [5:0]       shift;
   logic [63:0]      fixed;
   logic [63:0]      total;
   logic             op_signed;

   // cnt runs down to zero; the shift is the number of chunks already retired.
   always_comb begin
      shift = 6'((ITERS - 1 - int'(cnt)) * BITS_PER_CYCLE);
   end

   mul_step #(
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .prod_in  (prod),
      .mcand    (mcand),
      .chunk    (mplier[BITS_PER_CYCLE-1:0]),
      .shift    (shift),
      .prod_out (prod_next)
   );

   // Sign fix-up and accumulation for the FIX cycle; 010/011 fall back to unsigned short ops.
   always_comb begin
      op_signed = cmd[2] & cmd[1];
      fixed     = neg ? (~prod + 64'd1) : prod;
      total     = fixed + acc;
   end

   // Sequencer FSM with registered status and result outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
         flag_n    <= 1'b0;
         flag_z    <= 1'b0;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
         acc       <= '0;
         neg       <= 1'b0;
         is_long   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     mcand   <= op_signed ? abs32(a) : a;
                     mplier  <= op_signed ? abs32(b) : b;
                     neg     <= op_signed & (a[31] ^ b[31]);
                     is_long <= cmd[2];
                     acc     <= !cmd[0] ? 64'd0 :
                                cmd[2]  ? {acc_hi, acc_lo} : {32'd0, acc_lo};
                     prod    <= '0;
                     cnt     <= CNT_W'(ITERS - 1);
                     busy    <= 1'b1;
                     state   <= CALC;
                  end
               end
               CALC: begin
                  prod   <= prod_next;
                  mplier <= mplier >> BITS_PER_CYCLE;
                  if (cnt == '0) begin
                     state <= FIX;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               FIX: begin
                  if (is_long) begin
                     result_lo <= total[31:0];
                     result_hi <= total[63:32];
                     flag_n    <= total[63];
                     flag_z    <= (total == 64'd0);
                  end else begin
                     result_lo <= total[31:0];
                     result_hi <= '0;
                     flag_n    <= total[31];
                     flag_z    <= (total[31:0] == 32'd0);
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: arithmetic reference model plus directed ops.
module tb_mul_sequencer;
   import mul_pkg::*;

   localparam int LAT = MUL_ITERS + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  cmd = 3'b000;
   logic [31:0] a = '0, b = '0, acc_lo = '0, acc_hi = '0;
   logic        busy, done, flag_n, flag_z;
   logic [31:0] result_lo, result_hi;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mul_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cmd       (cmd),
      .a         (a),
      .b         (b),
      .acc_lo    (acc_lo),
      .acc_hi    (acc_hi),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .flag_n    (flag_n),
      .flag_z    (flag_z)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic, returns {n, z, result64}.
   function automatic logic [65:0] model(input logic [2:0] c, input logic [31:0] ia, input logic [31:0] ib,
                                         input logic [31:0] lo, input logic [31:0] hi);
      logic [63:0] p, ac, r;
      logic        n, z;
      if (c[2] && c[1]) p = 64'(longint'($signed(ia)) * longint'($signed(ib)));
      else              p = {32'd0, ia} * {32'd0, ib};
      if (!c[0])     ac = 64'd0;
      else if (c[2]) ac = {hi, lo};
      else           ac = {32'd0, lo};
      r = p + ac;
      if (!c[2]) r[63:32] = 32'd0;
      n = c[2] ? r[63] : r[31];
      z = (r == 64'd0);
      return {n, z, r};
   endfunction

   // Cycle-level expectation: accept when idle, done LAT edges later, flush/reset abort.
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   int          m_left = 0;
   logic [65:0] m_exp  = '0;
   logic [65:0] m_pend = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_left = 0;
         m_exp  = '0;
      end else begin
         m_done = 1'b0;
         if (flush) begin
            m_busy = 1'b0;
         end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_exp  = m_pend;
            end
         end else if (start) begin
            m_busy = 1'b1;
            m_left = LAT;
            m_pend = model(cmd, a, b, acc_lo, acc_hi);
         end
      end
   end

   // Every cycle, all outputs must match the model.
   always @(negedge clk) begin
      check("busy",   busy, m_busy);
      check("done",   done, m_done);
      check("result", {result_hi, result_lo}, m_exp[63:0]);
      check("flag_n", flag_n, m_exp[65]);
      check("flag_z", flag_z, m_exp[64]);
      check("done_and_busy", busy & done, 1'b0);
   end

   task automatic issue(input logic [2:0] c, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] lo, input logic [31:0] hi);
      @(negedge clk);
      cmd = c; a = ia; b = ib; acc_lo = lo; acc_hi = hi;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // operands must have been latched at accept
      cmd = 3'($urandom); a = $urandom; b = $urandom; acc_lo = $urandom; acc_hi = $urandom;
   endtask

   task automatic wait_done(inout int n);
      while (done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_lit(input string nm, input logic [2:0] c, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] lo, input logic [31:0] hi,
                          input logic [63:0] e, input logic en, input logic ez);
      int n;
      n = 0;
      issue(c, ia, ib, lo, hi);
      wait_done(n);
      check({nm, "_lat"}, 64'(n), 64'(LAT));
      check({nm, "_res"}, {result_hi, result_lo}, e);
      check({nm, "_n"}, flag_n, en);
      check({nm, "_z"}, flag_z, ez);
   endtask

   logic [2:0]  v_cmd [6] = '{3'b101, 3'b110, 3'b111, 3'b010, 3'b011, 3'b000};
   logic [31:0] v_a   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'h0001_0000, 32'h1234_5678, 32'hDEAD_BEEF};
   logic [31:0] v_b   [6] = '{32'h0000_0002, 32'h0000_1000, 32'h8000_0001, 32'h0001_0000, 32'h0000_0010, 32'h0000_0003};
   logic [31:0] v_lo  [6] = '{32'hFFFF_FFFF, 32'h1111_1111, 32'h0000_0005, 32'h5555_5555, 32'hFFFF_FFFF, 32'h0000_0009};
   logic [31:0] v_hi  [6] = '{32'hFFFF_FFFF, 32'h2222_2222, 32'h8000_0000, 32'h6666_6666, 32'h7777_7777, 32'h0000_0008};

   initial begin
      int n;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", {result_hi, result_lo}, 64'd0);
      check("rst_flags", {flag_n, flag_z}, 2'b00);

      check("pin_umull", model(CMD_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0), {2'b10, 64'hFFFF_FFFE_0000_0001});
      check("pin_smlal", model(CMD_SMLAL, 32'hFFFF_FFFD, 32'd5, 32'hF, 32'd0), {2'b01, 64'd0});
      check("pin_smull", model(CMD_SMULL, 32'h8000_0000, 32'h8000_0000, 0, 0), {2'b00, 64'h4000_0000_0000_0000});

      run_lit("mul",   CMD_MUL,   32'd7, 32'd6, 32'd0, 32'd0, 64'd42, 1'b0, 1'b0);
      run_lit("umull", CMD_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);
      run_lit("smlal", CMD_SMLAL, 32'hFFFF_FFFD, 32'd5, 32'h0000_000F, 32'd0, 64'd0, 1'b0, 1'b1);
      run_lit("smull", CMD_SMULL, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 64'h4000_0000_0000_0000, 1'b0, 1'b0);

      // flush mid-CALC: no done, outputs hold the SMULL result
      issue(CMD_UMULL, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0);
      repeat (7) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", busy, 1'b0);
      n = 0;
      repeat (25) begin
         @(negedge clk);
         if (done === 1'b1) n++;
      end
      check("flush_no_done", 64'(n), 64'd0);
      check("flush_hold", {result_hi, result_lo}, 64'h4000_0000_0000_0000);

      // flush and start together: start dropped
      @(negedge clk);
      cmd = CMD_MUL; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", busy, 1'b0);

      run_lit("mla", CMD_MLA, 32'd2, 32'd3, 32'hFFFF_FFFA, 32'h0000_1234, 64'd0, 1'b0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         n = 0;
         issue(v_cmd[i], v_a[i], v_b[i], v_lo[i], v_hi[i]);
         wait_done(n);
         check("vec_lat", 64'(n), 64'(LAT));
      end

      // start pulsed mid-op is ignored
      n = 0;
      issue(CMD_MUL, 32'd9, 32'd11, 32'd0, 32'd0);
      repeat (5) begin
         @(negedge clk);
         n++;
      end
      cmd = CMD_MUL; a = 32'd100; b = 32'd100; start = 1'b1;
      @(negedge clk);
      n++;
      start = 1'b0;
      wait_done(n);
      check("ign_lat", 64'(n), 64'(LAT));
      check("ign_res", {result_hi, result_lo}, 64'd99);
      repeat (20) @(negedge clk);
      check("ign_idle", busy, 1'b0);

      // start held through done: second op accepted in the done cycle
      @(negedge clk);
      cmd = CMD_MUL; a = 32'd3; b = 32'd4; acc_lo = 0; acc_hi = 0; start = 1'b1;
      @(negedge clk);
      n = 0;
      wait_done(n);
      check("b2b_lat1", 64'(n), 64'(LAT));
      check("b2b_res1", {result_hi, result_lo}, 64'd12);
      check("b2b_idle_in_done", busy, 1'b0);
      a = 32'd5; b = 32'd6;
      @(negedge clk);
      check("b2b_accept", busy, 1'b1);
      start = 1'b0;
      n = 0;
      wait_done(n);
      check("b2b_lat2", 64'(n), 64'(LAT));
      check("b2b_res2", {result_hi, result_lo}, 64'd30);

      // reset mid-op clears everything immediately
      run_lit("umull2", CMD_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);
      issue(CMD_SMULL, 32'd1234, 32'hFFFF_0000, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_done", done, 1'b0);
      check("rstmid_result", {result_hi, result_lo}, 64'd0);
      check("rstmid_flags", {flag_n, flag_z}, 2'b00);
      @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      check("rstmid_idle", busy, 1'b0);

      run_lit("mul2", CMD_MUL, 32'd7, 32'd6, 32'd0, 32'd0, 64'd42, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
